// File: rtl/uart_tx_arbiter_if.sv
// Requester/UART-side bundle for the UART transmit arbiter.
interface uart_tx_arbiter_if #(
    parameter int unsigned NREQ = 4
);
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   ack;
    logic [NREQ-1:0]   grant;
    logic [7:0]        uart_data;
    logic              uart_start;
    logic              uart_busy;
    logic              err;
    logic [15:0]       byte_cnt;

    // Arbiter side
    modport master (
        input  req, req_data, uart_busy,
        output ack, grant, uart_data, uart_start, err, byte_cnt
    );

    // Requesters + UART side
    modport slave (
        output req, req_data, uart_busy,
        input  ack, grant, uart_data, uart_start, err, byte_cnt
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among four requesters.
module uart_tx_arbiter #(
    parameter int unsigned NREQ         = 4,
    parameter int unsigned BUSY_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    uart_tx_arbiter_if.master  bus
);
    localparam int unsigned IDX_W = $clog2(NREQ);
    localparam int unsigned CNT_W = $clog2(BUSY_TIMEOUT);
    localparam int unsigned BCW   = 16;

    typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE, GAP} state_t;

    state_t             r_state, w_state;
    logic [IDX_W-1:0]   r_last, w_last;
    logic [CNT_W-1:0]   r_cnt, w_cnt;
    logic [NREQ-1:0]    r_grant, w_grant;
    logic [NREQ-1:0]    r_ack, w_ack;
    logic [7:0]         r_data, w_data;
    logic               r_start, w_start;
    logic               r_err, w_err;
    logic [BCW-1:0]     r_byte_cnt, w_byte_cnt;

    logic               w_found;
    logic [IDX_W-1:0]   w_idx;
    logic [IDX_W-1:0]   w_cand;
    logic [7:0]         w_byte;

    // Round-robin search starting one past the previous winner
    always_comb begin
        w_found = 1'b0;
        w_idx   = r_last;
        w_cand  = r_last;
        for (int unsigned i = 0; i < NREQ; i++) begin
            w_cand = r_last + IDX_W'(i + 1);
            if (!w_found && bus.req[w_cand]) begin
                w_found = 1'b1;
                w_idx   = w_cand;
            end
        end
    end

    // Byte belonging to the search winner
    always_comb begin
        w_byte = 8'h00;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (w_idx == IDX_W'(i)) begin
                w_byte = bus.req_data[i*8 +: 8];
            end
        end
    end

    // State register and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_last     <= IDX_W'(NREQ - 1);
            r_cnt      <= '0;
            r_grant    <= '0;
            r_ack      <= '0;
            r_data     <= 8'h00;
            r_start    <= 1'b0;
            r_err      <= 1'b0;
            r_byte_cnt <= '0;
        end else begin
            r_state    <= w_state;
            r_last     <= w_last;
            r_cnt      <= w_cnt;
            r_grant    <= w_grant;
            r_ack      <= w_ack;
            r_data     <= w_data;
            r_start    <= w_start;
            r_err      <= w_err;
            r_byte_cnt <= w_byte_cnt;
        end
    end

    // Next-state and next-output logic; strobes default low
    always_comb begin
        w_state    = r_state;
        w_last     = r_last;
        w_cnt      = r_cnt;
        w_grant    = r_grant;
        w_data     = r_data;
        w_start    = 1'b0;
        w_ack      = '0;
        w_err      = 1'b0;
        w_byte_cnt = r_byte_cnt;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_grant = NREQ'(1) << w_idx;
                    w_data  = w_byte;
                    w_start = 1'b1;
                    w_last  = w_idx;
                    w_cnt   = '0;
                    w_state = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (bus.uart_busy) begin
                    w_state = WAIT_DONE;
                end else if (r_cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
                    w_ack   = r_grant;
                    w_err   = 1'b1;
                    w_state = GAP;
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!bus.uart_busy) begin
                    w_ack      = r_grant;
                    w_byte_cnt = r_byte_cnt + BCW'(1);
                    w_state    = GAP;
                end
            end
            GAP: begin
                // Requests are ignored here so the acked owner can withdraw
                w_grant = '0;
                w_state = IDLE;
            end
            default: w_state = IDLE;
        endcase
    end

    assign bus.ack        = r_ack;
    assign bus.grant      = r_grant;
    assign bus.uart_data  = r_data;
    assign bus.uart_start = r_start;
    assign bus.err        = r_err;
    assign bus.byte_cnt   = r_byte_cnt;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a simple UART busy model.
module tb_uart_tx_arbiter;
    logic clk;
    logic rst;

    uart_tx_arbiter_if bus ();

    uart_tx_arbiter #(.NREQ(4), .BUSY_TIMEOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0]  grant;
        logic [7:0]  data;
        logic        err;
        logic [15:0] cnt;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int start_cyc = 0;
    int n_starts = 0;
    int rem[4];
    bit chk_clr = 0;
    bit model_en = 1;
    bit pend = 0;
    int blen = 3;
    int left = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push(input logic [3:0] g, input logic [7:0] d, input logic er,
                        input logic [15:0] c, input int lat);
        exp_t x;
        x.grant = g; x.data = d; x.err = er; x.cnt = c; x.lat = lat;
        exp_q.push_back(x);
    endtask

    task automatic set_req(input int i, input int n);
        rem[i] = n;
        bus.req[i] = (n != 0);
    endtask

    function automatic bit any_rem();
        return (rem[0] != 0) || (rem[1] != 0) || (rem[2] != 0) || (rem[3] != 0);
    endfunction

    task automatic drain(input string name);
        int t = 0;
        while ((exp_q.size() != 0 || any_rem()) && t < 300) begin
            tick(1);
            t++;
        end
        if (t >= 300) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: drain timed out, %0d transfers still expected", name, exp_q.size());
            exp_q.delete();
            for (int i = 0; i < 4; i++) set_req(i, 0);
        end
        tick(2);
    endtask

    // Requesters: hold req until acked the requested number of times
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (bus.ack[i] && rem[i] > 0) begin
                    rem[i]--;
                    if (rem[i] == 0) bus.req[i] = 1'b0;
                end
            end
        end
    end

    // UART model: start detection
    initial begin
        forever begin
            @(negedge clk);
            if (bus.uart_start && model_en) pend = 1;
        end
    end

    // UART model: busy high for blen cycles starting one edge after start
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                bus.uart_busy = 1'b0;
                left = 0;
                pend = 0;
            end else if (left > 0) begin
                left--;
                bus.uart_busy = (left != 0);
            end else if (pend) begin
                pend = 0;
                bus.uart_busy = 1'b1;
                left = blen;
            end
        end
    end

    // Monitor: compare every start and ack against the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (chk_clr) begin
                check("grant_clear", 32'(bus.grant), 32'h0);
                chk_clr = 0;
            end
            if (bus.uart_start) begin
                n_starts++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_start: grant %0h data %0h, none expected", bus.grant, bus.uart_data);
                end else begin
                    check("start_grant", 32'(bus.grant), 32'(exp_q[0].grant));
                    check("start_data", 32'(bus.uart_data), 32'(exp_q[0].data));
                    start_cyc = cyc;
                end
            end
            if (bus.ack != 4'b0) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_ack: ack %0h, none expected", bus.ack);
                end else begin
                    e = exp_q.pop_front();
                    check("ack", 32'(bus.ack), 32'(e.grant));
                    check("err", 32'(bus.err), 32'(e.err));
                    check("byte_cnt", 32'(bus.byte_cnt), 32'(e.cnt));
                    check("data_held", 32'(bus.uart_data), 32'(e.data));
                    check("ack_latency", 32'(cyc - start_cyc), 32'(e.lat));
                    chk_clr = 1;
                end
            end else if (bus.err) begin
                n_cmp++;
                n_bad++;
                $display("FAIL err_without_ack: err 1 ack 0");
            end
        end
    end

    // Watchdog
    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: bench did not finish in 20000 cycles");
        $fatal(1, "watchdog");
    end

    // Directed stimulus
    initial begin
        rst = 1;
        bus.req = '0;
        bus.req_data = '0;
        bus.uart_busy = 1'b0;
        for (int i = 0; i < 4; i++) rem[i] = 0;
        tick(3);
        check("rst_grant", 32'(bus.grant), 32'h0);
        check("rst_ack", 32'(bus.ack), 32'h0);
        check("rst_data", 32'(bus.uart_data), 32'h0);
        check("rst_start", 32'(bus.uart_start), 32'h0);
        check("rst_err", 32'(bus.err), 32'h0);
        check("rst_byte_cnt", 32'(bus.byte_cnt), 32'h0);
        rst = 0;
        tick(2);

        // All four requesting: order 0,1,2,3,0
        blen = 3;
        bus.req_data = 32'h4332_2110;
        push(4'b0001, 8'h10, 0, 16'd1, 5);
        push(4'b0010, 8'h21, 0, 16'd2, 5);
        push(4'b0100, 8'h32, 0, 16'd3, 5);
        push(4'b1000, 8'h43, 0, 16'd4, 5);
        push(4'b0001, 8'h10, 0, 16'd5, 5);
        set_req(0, 2); set_req(1, 1); set_req(2, 1); set_req(3, 1);
        drain("round_robin");

        // Single request, 20-cycle busy
        blen = 20;
        bus.req_data[7:0] = 8'h5A;
        push(4'b0001, 8'h5A, 0, 16'd6, 22);
        set_req(0, 1);
        drain("single");

        // Busy never rises: timeout, then a normal transfer
        model_en = 0;
        bus.req_data[23:16] = 8'h77;
        push(4'b0100, 8'h77, 1, 16'd6, 16);
        set_req(2, 1);
        drain("timeout");
        model_en = 1;
        blen = 2;
        bus.req_data[23:16] = 8'h78;
        push(4'b0100, 8'h78, 0, 16'd7, 4);
        set_req(2, 1);
        drain("after_timeout");

        // Owner changes data mid-transfer; requester 1 withdraws before grant
        blen = 20;
        bus.req_data[31:24] = 8'h9C;
        push(4'b1000, 8'h9C, 0, 16'd8, 22);
        set_req(3, 1);
        tick(2);
        bus.req_data[31:24] = 8'hEE;
        set_req(1, 1);
        tick(5);
        set_req(1, 0);
        drain("withdraw");
        tick(5);
        check("starts_total_a", 32'(n_starts), 32'd9);

        // Reset during WAIT_DONE
        blen = 20;
        bus.req_data[7:0] = 8'h11;
        push(4'b0001, 8'h11, 0, 16'd9, 22);
        set_req(0, 1);
        tick(8);
        rst = 1;
        set_req(0, 0);
        tick(1);
        check("midrst_grant", 32'(bus.grant), 32'h0);
        check("midrst_ack", 32'(bus.ack), 32'h0);
        check("midrst_byte_cnt", 32'(bus.byte_cnt), 32'h0);
        check("midrst_start", 32'(bus.uart_start), 32'h0);
        rst = 0;
        exp_q.delete();
        tick(2);

        // Priority restarts at requester 0 after reset
        blen = 3;
        bus.req_data[7:0] = 8'h31;
        bus.req_data[15:8] = 8'h41;
        push(4'b0001, 8'h31, 0, 16'd1, 5);
        push(4'b0010, 8'h41, 0, 16'd2, 5);
        set_req(0, 1); set_req(1, 1);
        drain("post_reset_rr");
        bus.req_data[23:16] = 8'h5C;
        push(4'b0100, 8'h5C, 0, 16'd3, 5);
        set_req(2, 1);
        drain("post_reset_req2");

        // Counter wrap from 0xFFFF
        force dut.r_byte_cnt = 16'hFFFF;
        tick(1);
        release dut.r_byte_cnt;
        tick(1);
        check("preload", 32'(bus.byte_cnt), 32'hFFFF);
        blen = 2;
        bus.req_data[15:8] = 8'hA5;
        push(4'b0010, 8'hA5, 0, 16'd0, 4);
        set_req(1, 1);
        drain("wrap");
        check("wrap_byte_cnt", 32'(bus.byte_cnt), 32'h0);
        check("starts_total_b", 32'(n_starts), 32'd14);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares the single UART transmitter among four on-board requesters: motor controller, sensor scanner, battery monitor and the J1 console path. It sits between those blocks and the UART peripheral's transmit side. It grants one requester at a time, latches that requester's byte, issues a one-cycle start to the UART and tracks `busy` to completion. It then acknowledges the requester and moves priority to the next one.

## Interface
- `NREQ`, 4: number of requesters; fixed at 4 for this revision.
- `BUSY_TIMEOUT`, 16: number of cycles to wait for `uart_busy` to rise after a start before declaring an error.
- `clk`  in  1  system clock, 100 MHz.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  4  per-requester send request; level, held until ack.
- `req_data`  in  32  packed bytes; requester i on bits [8i+7:8i].
- `ack`  out  4  one-cycle pulse to the requester whose byte has finished (or timed out).
- `grant`  out  4  one-hot; owner of the UART during a transfer, 0 when idle.
- `uart_data`  out  8  byte presented to the UART; held stable for the whole transfer.
- `uart_start`  out  1  one-cycle load/start strobe to the UART.
- `uart_busy`  in  1  UART transmit-busy flag.
- `err`  out  1  one-cycle pulse on a busy timeout.
- `byte_cnt`  out  16  count of bytes completed without error; wraps 0xFFFF to 0.

## Operation
- FSM states: IDLE, WAIT_BUSY, WAIT_DONE, GAP.
- **IDLE:** if any `req` bit is high, pick the winner with round-robin. The search starts at `last+1` mod 4, where `last` is the most recent winner. On that edge:
  - set `grant` one-hot for the winner;
  - set `uart_data` to the winner's byte;
  - set `uart_start` to 1;
  - set `last` to the winner;
  - clear the timeout counter;
  - go to WAIT_BUSY.
- **WAIT_BUSY:** `uart_start` returns to 0.
  - If `uart_busy`=1, go to WAIT_DONE.
  - Otherwise increment the counter. When the counter reaches `BUSY_TIMEOUT`-1, pulse `ack[g]` and `err`, then go to GAP. `byte_cnt` is unchanged.
- **WAIT_DONE:** when `uart_busy`=0, pulse `ack[g]`, increment `byte_cnt` and go to GAP.
- **GAP:** lasts exactly one cycle, during which `ack` is high. Clear `grant` and go to IDLE.
  - `req` is not sampled in GAP. This gives the acked requester one cycle to drop `req` or change its byte.
- Latching and withdrawal:
  - The byte is latched at grant. Later changes to `req_data` or `req` from the owner have no effect on the transfer in progress.
  - A non-granted requester may drop `req` at any time without side effects.
- `last` resets to 3, so requester 0 has first priority after reset.
- If only one requester is active, it is granted back-to-back. Its bytes are spaced by the UART frame time plus 2 cycles.

## Timing
- **Reset values:** `ack`=0, `grant`=0, `uart_data`=0, `uart_start`=0, `err`=0, `byte_cnt`=0, state IDLE, `last`=3, timeout counter 0.
- All outputs are registered.
- **req to start:** `req` is sampled high at edge k in IDLE. `grant`, `uart_data` and `uart_start` are valid after edge k; `uart_start` is high for cycle k..k+1 only.
- **busy fall to ack:** `uart_busy` is seen low at edge m in WAIT_DONE. `ack` is high after edge m for exactly one cycle, and `grant` clears after edge m+1.
- **Earliest next grant:** edge m+2.
- **Timeout:** `ack` and `err` assert `BUSY_TIMEOUT` cycles after the `uart_start` cycle.
- **Reset mid-transfer:** everything returns to reset values on the next edge; no `ack` is issued. The UART side is reset by the same `rst`.
- **Simultaneous requests:** exactly one grant, following round-robin order; there are never two `grant` or `ack` bits high at once.
- **`uart_busy` already high in IDLE:** ignored. In WAIT_BUSY it is accepted immediately on the next edge.

## Test plan
- **Single request:** `req`=0001, byte 0x5A, UART model busy for 20 cycles.
  - `uart_start` pulses once with `uart_data`=0x5A and `grant`=0001.
  - `ack`=0001 one cycle after busy falls; `byte_cnt`=1.
- **All four requesting continuously:** bytes 0x10/0x21/0x32/0x43.
  - Grant order is 0,1,2,3,0; the UART sees 0x10,0x21,0x32,0x43,0x10.
  - Each `ack` bit pulses once per byte.
- **Timeout:** `req`=0100, UART model never raises busy.
  - `err` and `ack`=0100 pulse 16 cycles after `uart_start`.
  - `byte_cnt` unchanged; the next request proceeds normally.
- **Reset mid-transfer:** assert `rst` for 1 cycle during WAIT_DONE.
  - Next cycle: `grant`=0, no `ack`, `byte_cnt`=0, `last`=3.
  - The next request from requester 2 alone is granted.
- **Withdrawal and latching:**
  - Requester 1 drops `req` before being granted: it is never granted or acked.
  - The owner changes `req_data` mid-transfer: `uart_data` stays at the latched value.
- **Counter wrap:** preload scenario with 65,536 completed bytes; `byte_cnt` reads 0 after the last byte.
